// File: rtl/trace_sniff_fifo_writer_pkg.sv
// Shared definitions for the trace sniff FIFO write path: entry command codes,
// the command field position and the writer state encoding.
package trace_sniff_fifo_writer_pkg;

  localparam int unsigned FE_FIFO_CMD_START   = 16;
  localparam int unsigned FE_FIFO_CMD_BIT_LEN = 2;

  localparam logic [FE_FIFO_CMD_BIT_LEN-1:0] CMD_MATCH = 2'd0;
  localparam logic [FE_FIFO_CMD_BIT_LEN-1:0] CMD_LTIME = 2'd1;
  localparam logic [FE_FIFO_CMD_BIT_LEN-1:0] CMD_STAT  = 2'd2;

  typedef enum logic [2:0] {
    StIdle,
    StArmed,
    StLtimePend,
    StBlocked,
    StDone
  } wr_state_e;

  function automatic logic [17:0] make_entry(logic [FE_FIFO_CMD_BIT_LEN-1:0] cmd,
                                             logic [15:0] payload);
    return {cmd, payload};
  endfunction

endpackage

// File: rtl/trace_sniff_fifo_writer_delta_ts.sv
// trace_delta_timestamp: saturating delta counter, cleared on arm and
// reloaded to 1 on every written match entry.
module trace_delta_timestamp #(
  parameter int unsigned pTS_WIDTH = 16
) (
  input  logic                 trace_clk,
  input  logic                 reset,
  input  logic                 i_clear,
  input  logic                 i_load_one,
  input  logic                 i_inc,
  output logic [pTS_WIDTH-1:0] o_ts
);

  logic [pTS_WIDTH-1:0] r_ts;

  always_ff @(posedge trace_clk) begin
    if (reset || i_clear) begin
      r_ts <= '0;
    end else if (i_load_one) begin
      r_ts <= pTS_WIDTH'(1);
    end else if (i_inc && (r_ts != '1)) begin
      r_ts <= r_ts + 1'b1;
    end
  end

  assign o_ts = r_ts;

endmodule

// File: rtl/trace_sniff_fifo_writer.sv
// Write-side sequencer for the trace sniff FIFO: turns matcher hits into
// MATCH/LTIME entries with delta timestamps and tracks the arm/capture lifecycle.
module trace_sniff_fifo_writer
  import trace_sniff_fifo_writer_pkg::*;
#(
  parameter int unsigned pTS_WIDTH        = 16,
  parameter int unsigned pEVENT_CNT_WIDTH = 16,
  parameter int unsigned pRULE_WIDTH      = 8
) (
  input  logic                        trace_clk,
  input  logic                        reset,
  input  logic                        arm,
  input  logic                        capture_enable,
  input  logic [pEVENT_CNT_WIDTH-1:0] max_events,
  input  logic                        match_valid,
  input  logic [pRULE_WIDTH-1:0]      match_rule,
  input  logic                        fifo_full,
  output logic                        fifo_wr,
  output logic [17:0]                 fifo_din,
  output logic                        armed,
  output logic                        capture_done,
  output logic                        overflow_blocked,
  output logic                        match_dropped,
  output logic [pEVENT_CNT_WIDTH-1:0] event_count
);

  wr_state_e                   r_state, w_state_next;
  logic                        r_fifo_wr;
  logic [17:0]                 r_fifo_din;
  logic [pEVENT_CNT_WIDTH-1:0] r_event_count;
  logic                        r_done, r_blocked, r_dropped;
  logic [7:0]                  r_rule;

  logic [pTS_WIDTH-1:0]        w_ts;
  logic [15:0]                 w_ts16;
  logic                        w_ts_long;
  logic [7:0]                  w_rule8;
  logic [pEVENT_CNT_WIDTH-1:0] w_cnt_plus;
  logic                        w_cnt_hits_max;
  logic                        w_wr, w_clear, w_ts_load1, w_ts_inc, w_cnt_inc, w_latch_rule;
  logic                        w_set_done, w_set_blocked, w_set_dropped;
  logic [17:0]                 w_din;

  assign w_ts16         = 16'(w_ts);
  assign w_ts_long      = |w_ts[pTS_WIDTH-1:8];
  assign w_rule8        = 8'(match_rule);
  assign w_cnt_plus     = (r_event_count == '1) ? r_event_count : r_event_count + 1'b1;
  assign w_cnt_hits_max = (max_events != '0) && (w_cnt_plus == max_events);

  trace_delta_timestamp #(
    .pTS_WIDTH (pTS_WIDTH)
  ) u_delta_ts (
    .trace_clk  (trace_clk),
    .reset      (reset),
    .i_clear    (w_clear),
    .i_load_one (w_ts_load1),
    .i_inc      (w_ts_inc),
    .o_ts       (w_ts)
  );

  always_comb begin
    w_state_next  = r_state;
    w_wr          = 1'b0;
    w_din         = r_fifo_din;
    w_clear       = 1'b0;
    w_ts_load1    = 1'b0;
    w_ts_inc      = 1'b0;
    w_cnt_inc     = 1'b0;
    w_latch_rule  = 1'b0;
    w_set_done    = 1'b0;
    w_set_blocked = 1'b0;
    w_set_dropped = 1'b0;
    if (!capture_enable) begin
      w_state_next = StIdle;
    end else if (arm) begin
      // A hit coincident with arm is deliberately ignored.
      w_state_next = StArmed;
      w_clear      = 1'b1;
    end else begin
      unique case (r_state)
        StArmed: begin
          w_ts_inc = 1'b1;
          if (match_valid) begin
            if (fifo_full) begin
              w_set_blocked = 1'b1;
              w_state_next  = StBlocked;
            end else if (w_ts_long) begin
              w_wr         = 1'b1;
              w_din        = make_entry(CMD_LTIME, w_ts16);
              w_latch_rule = 1'b1;
              w_state_next = StLtimePend;
            end else begin
              w_wr       = 1'b1;
              w_din      = make_entry(CMD_MATCH, {w_rule8, w_ts[7:0]});
              w_ts_load1 = 1'b1;
              w_cnt_inc  = 1'b1;
              if (w_cnt_hits_max) begin
                w_set_done   = 1'b1;
                w_state_next = StDone;
              end
            end
          end
        end
        StLtimePend: begin
          w_set_dropped = match_valid;
          if (fifo_full) begin
            w_set_blocked = 1'b1;
            w_state_next  = StBlocked;
          end else begin
            w_wr         = 1'b1;
            w_din        = make_entry(CMD_MATCH, {r_rule, 8'd0});
            w_ts_load1   = 1'b1;
            w_cnt_inc    = 1'b1;
            w_state_next = w_cnt_hits_max ? StDone : StArmed;
            w_set_done   = w_cnt_hits_max;
          end
        end
        StIdle, StBlocked, StDone: ;
        default: w_state_next = StIdle;
      endcase
    end
  end

  always_ff @(posedge trace_clk) begin
    if (reset) begin
      r_state       <= StIdle;
      r_fifo_wr     <= 1'b0;
      r_fifo_din    <= '0;
      r_event_count <= '0;
      r_done        <= 1'b0;
      r_blocked     <= 1'b0;
      r_dropped     <= 1'b0;
      r_rule        <= '0;
    end else begin
      r_state   <= w_state_next;
      r_fifo_wr <= w_wr;
      if (w_wr) r_fifo_din <= w_din;
      if (w_latch_rule) r_rule <= w_rule8;
      if (w_clear) begin
        r_event_count <= '0;
        r_done        <= 1'b0;
        r_blocked     <= 1'b0;
        r_dropped     <= 1'b0;
      end else begin
        if (w_cnt_inc) r_event_count <= w_cnt_plus;
        r_done    <= r_done | w_set_done;
        r_blocked <= r_blocked | w_set_blocked;
        r_dropped <= r_dropped | w_set_dropped;
      end
    end
  end

  assign fifo_wr          = r_fifo_wr;
  assign fifo_din         = r_fifo_din;
  assign armed            = (r_state == StArmed) || (r_state == StLtimePend);
  assign capture_done     = r_done;
  assign overflow_blocked = r_blocked;
  assign match_dropped    = r_dropped;
  assign event_count      = r_event_count;

endmodule

// File: tb/tb_trace_sniff_fifo_writer.sv
// Randomised + directed bench for trace_sniff_fifo_writer: a timeline model
// predicts FIFO entries into a queue that a negedge monitor drains.
module tb_trace_sniff_fifo_writer;

  logic        trace_clk = 1'b0;
  logic        reset, arm, capture_enable, match_valid, fifo_full;
  logic [15:0] max_events;
  logic [7:0]  match_rule;
  logic        fifo_wr, armed, capture_done, overflow_blocked, match_dropped;
  logic [17:0] fifo_din;
  logic [15:0] event_count;

  always #5 trace_clk = ~trace_clk;

  trace_sniff_fifo_writer dut (
    .trace_clk        (trace_clk),
    .reset            (reset),
    .arm              (arm),
    .capture_enable   (capture_enable),
    .max_events       (max_events),
    .match_valid      (match_valid),
    .match_rule       (match_rule),
    .fifo_full        (fifo_full),
    .fifo_wr          (fifo_wr),
    .fifo_din         (fifo_din),
    .armed            (armed),
    .capture_done     (capture_done),
    .overflow_blocked (overflow_blocked),
    .match_dropped    (match_dropped),
    .event_count      (event_count)
  );

  typedef struct {
    logic [17:0] din;
    int unsigned cyc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int unsigned cyc = 0;
  int          checks = 0;
  int          failures = 0;

  always @(posedge trace_clk) cyc <= cyc + 1;

  // Model: m_mode 0 idle, 1 capturing, 2 blocked, 3 done. ts at edge t is t - m_ref.
  int unsigned m_mode, m_ref, m_cnt;
  bit          m_pend, m_done, m_blk, m_drop;
  logic [7:0]  m_rule_l;

  task automatic push(input logic [17:0] din, input int unsigned t);
    exp_t e;
    e.din = din;
    e.cyc = t;
    exp_q.push_back(e);
  endtask

  task automatic log_match(input logic [7:0] r, input logic [7:0] lo, input int unsigned t);
    push({2'd0, r, lo}, t);
    if (m_cnt < 65535) m_cnt++;
    m_ref = t;
    if (max_events != 0 && m_cnt == max_events) begin
      m_done = 1;
      m_mode = 3;
    end
  endtask

  task automatic model_step();
    int unsigned t;
    int unsigned d;
    t = cyc + 1;
    if (reset) begin
      m_mode = 0; m_pend = 0; m_cnt = 0; m_done = 0; m_blk = 0; m_drop = 0;
    end else if (!capture_enable) begin
      m_mode = 0; m_pend = 0;
    end else if (arm) begin
      m_mode = 1; m_pend = 0; m_ref = t + 1; m_cnt = 0; m_done = 0; m_blk = 0; m_drop = 0;
    end else if (m_pend) begin
      m_pend = 0;
      if (match_valid) m_drop = 1;
      if (fifo_full) begin
        m_blk = 1; m_mode = 2;
      end else begin
        log_match(m_rule_l, 8'd0, t);
      end
    end else if (m_mode == 1 && match_valid) begin
      d = t - m_ref;
      if (d > 65535) d = 65535;
      if (fifo_full) begin
        m_blk = 1; m_mode = 2;
      end else if (d <= 255) begin
        log_match(match_rule, d[7:0], t);
      end else begin
        push({2'd1, d[15:0]}, t);
        m_pend = 1;
        m_rule_l = match_rule;
      end
    end
  endtask

  task automatic drive(input bit a, input bit mv, input logic [7:0] r);
    arm = a;
    match_valid = mv;
    match_rule = r;
    model_step();
    @(negedge trace_clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, act, want);
    end
  endtask

  task automatic status(input string n);
    chk({n, " event_count"}, 32'(event_count), m_cnt);
    chk({n, " capture_done"}, 32'(capture_done), 32'(m_done));
    chk({n, " overflow_blocked"}, 32'(overflow_blocked), 32'(m_blk));
    chk({n, " match_dropped"}, 32'(match_dropped), 32'(m_drop));
    chk({n, " armed"}, 32'(armed), 32'(m_mode == 1));
  endtask

  always @(negedge trace_clk) begin
    if (fifo_wr === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected got din=%05h cyc=%0d want no write", fifo_din, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (fifo_din !== mon_e.din || cyc != mon_e.cyc) begin
          failures++;
          $display("FAIL sb_entry got din=%05h cyc=%0d want din=%05h cyc=%0d",
                   fifo_din, cyc, mon_e.din, mon_e.cyc);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned gap;
    reset = 1'b1; arm = 1'b0; capture_enable = 1'b1; max_events = 16'd0;
    match_valid = 1'b0; match_rule = 8'd0; fifo_full = 1'b0;
    idle(3);
    reset = 1'b0;
    chk("reset fifo_wr", 32'(fifo_wr), 0);
    chk("reset fifo_din", 32'(fifo_din), 0);
    status("reset");

    // Two short hits at 5 and 6 cycles after arm.
    drive(1, 0, 0); idle(4); drive(0, 1, 8'd1); drive(0, 1, 8'd1); idle(2);
    status("short");

    // Long delta, then a hit that lands in the pending slot.
    drive(1, 0, 0); idle(299); drive(0, 1, 8'd3); drive(0, 1, 8'd9); idle(2);
    status("long");

    // FIFO full blocks, re-arm recovers.
    fifo_full = 1'b1;
    drive(1, 0, 0); idle(3); drive(0, 1, 8'd4); idle(2);
    status("blocked");
    drive(0, 1, 8'd5); drive(0, 1, 8'd6); idle(1);
    status("blocked_hold");
    fifo_full = 1'b0;
    drive(1, 0, 0);
    status("rearm");
    idle(2); drive(0, 1, 8'd7); idle(2);
    status("after_rearm");

    // max_events limit.
    max_events = 16'd3;
    drive(1, 0, 0);
    for (int i = 0; i < 5; i++) begin idle(1); drive(0, 1, 8'(8 + i)); end
    idle(2);
    status("max_events");
    max_events = 16'd0;

    // Saturated timestamp.
    drive(1, 0, 0); idle(70000); drive(0, 1, 8'd2); idle(2);
    status("saturate");

    // Reset while an LTIME entry is pending its MATCH.
    drive(1, 0, 0); idle(299); drive(0, 1, 8'd3);
    reset = 1'b1; drive(0, 0, 0); reset = 1'b0;
    chk("rst_pend fifo_wr", 32'(fifo_wr), 0);
    chk("rst_pend fifo_din", 32'(fifo_din), 0);
    status("rst_pend");
    idle(2);
    // Arm coincident with a hit: hit ignored, following hit sees ts=0.
    drive(1, 1, 8'd6); drive(0, 1, 8'd7); idle(2);
    status("arm_hit");

    // capture_enable low returns to idle with flags held.
    drive(1, 0, 0); idle(3); drive(0, 1, 8'd1);
    capture_enable = 1'b0; drive(0, 1, 8'd2); idle(1);
    status("disable");
    capture_enable = 1'b1; idle(2);

    // Randomised captures.
    for (int c = 0; c < 5; c++) begin
      max_events = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(1, 8));
      drive(1, 0, 0);
      for (int h = 0; h < 12; h++) begin
        gap = ($urandom_range(0, 4) == 0) ? $urandom_range(250, 300) : $urandom_range(1, 20);
        idle(int'(gap) - 1);
        drive(0, 1, 8'($urandom));
      end
      idle(3);
      status("random");
    end

    idle(4);
    chk("sb_drain", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
